// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types and constants for the LFSR stimulus sequencer
//
// Contents:
//   seq_state_e   sequencer FSM states (IDLE, RUN, DONE)
//   LFSR_TAPS_32  default Fibonacci tap mask for a 32-bit lane (taps 32,22,2,1)
//   nonzero_32    maps an all-zero lane value to 1 so a lane can never lock up

package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Bit i set means state[i] feeds the XOR.
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

    // An all-zero Fibonacci LFSR stays at zero forever.
    function automatic logic [31:0] nonzero_32(input logic [31:0] v);
        return (v == 32'd0) ? 32'd1 : v;
    endfunction

endpackage

// File: rtl/lfsr_digit_step.sv
// rtl/lfsr_digit_step.sv - advances one Fibonacci LFSR lane by one digit
//
// Purely combinational: applies RADIX_BITS consecutive single-bit steps in one
// cycle. Each step shifts left and inserts the parity of the tapped bits.
//
// Ports:
//   state_in   in   LFSR_SIZE   current lane state
//   state_out  out  LFSR_SIZE   lane state after RADIX_BITS steps

module lfsr_digit_step
    import lfsr_pkg::*;
#(
    parameter int                   LFSR_SIZE  = 32,
    parameter int                   RADIX_BITS = 3,
    parameter logic [LFSR_SIZE-1:0] LFSR_TAPS  = LFSR_TAPS_32
) (
    input  logic [LFSR_SIZE-1:0] state_in,
    output logic [LFSR_SIZE-1:0] state_out
);

    always_comb begin
        logic [LFSR_SIZE-1:0] s;
        s = state_in;
        for (int i = 0; i < RADIX_BITS; i++) begin
            s = {s[LFSR_SIZE-2:0], ^(s & LFSR_TAPS)};
        end
        state_out = s;
    end

endmodule

// File: rtl/lfsr_stim_sequencer.sv
// rtl/lfsr_stim_sequencer.sv - frame sequencer emitting paired LFSR operand digits
//
// Owns two LFSR lanes (X, Y) and streams their low RADIX_BITS bits as digit
// pairs, MSD first, NO_OF_DIGITS per frame, for num_frames frames per run.
// Lanes advance only on an accepted digit, so stalls never skip stimulus and
// consecutive runs continue the same pseudo-random sequence.
//
// Ports:
//   clk         in   1             clock, rising edge
//   reset       in   1             asynchronous active-low reset
//   start       in   1             begin a run (IDLE only)
//   num_frames  in   FRAME_CNT_W   frames in the run, sampled with start
//   stop        in   1             abort the current run (RUN only)
//   seed_load   in   1             load seed / ~seed into X / Y lanes (IDLE only)
//   seed        in   LFSR_SIZE     seed value
//   busy        out  1             run in progress
//   done        out  1             one-cycle pulse on normal completion
//   dig_valid   out  1             digit pair available
//   dig_ready   in   1             consumer accepts digit pair
//   dig_x       out  RADIX_BITS    X operand digit
//   dig_y       out  RADIX_BITS    Y operand digit
//   dig_first   out  1             digit is the MSD of its frame
//   dig_last    out  1             digit is the LSD of its frame
//   frame_idx   out  FRAME_CNT_W   0-based index of the current frame

module lfsr_stim_sequencer
    import lfsr_pkg::*;
#(
    parameter int                   NO_OF_DIGITS = 8,
    parameter int                   RADIX_BITS   = 3,
    parameter int                   LFSR_SIZE    = 32,
    parameter logic [LFSR_SIZE-1:0] LFSR_TAPS    = LFSR_TAPS_32,
    parameter int                   INIT_OFFSET  = 0,
    parameter int                   FRAME_CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [FRAME_CNT_W-1:0] num_frames,
    input  logic                   stop,
    input  logic                   seed_load,
    input  logic [LFSR_SIZE-1:0]   seed,
    output logic                   busy,
    output logic                   done,
    output logic                   dig_valid,
    input  logic                   dig_ready,
    output logic [RADIX_BITS-1:0]  dig_x,
    output logic [RADIX_BITS-1:0]  dig_y,
    output logic                   dig_first,
    output logic                   dig_last,
    output logic [FRAME_CNT_W-1:0] frame_idx
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_RUN  = 2'(RUN);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    localparam int CNT_W = (NO_OF_DIGITS > 1) ? $clog2(NO_OF_DIGITS) : 1;

    localparam logic [LFSR_SIZE-1:0] X_PRESET  = LFSR_SIZE'(INIT_OFFSET + 1);
    localparam logic [LFSR_SIZE-1:0] Y_PRESET  = LFSR_SIZE'(INIT_OFFSET + 2);
    localparam logic [CNT_W-1:0]     LAST_DIG  = CNT_W'(NO_OF_DIGITS - 1);
    localparam logic [LFSR_SIZE-1:0] LANE_ONE  = LFSR_SIZE'(1);

    logic [1:0]             state;
    logic [LFSR_SIZE-1:0]   lfsr_x;
    logic [LFSR_SIZE-1:0]   lfsr_y;
    logic [LFSR_SIZE-1:0]   lfsr_x_adv;
    logic [LFSR_SIZE-1:0]   lfsr_y_adv;
    logic [LFSR_SIZE-1:0]   seed_x;
    logic [LFSR_SIZE-1:0]   seed_y;
    logic [CNT_W-1:0]       digit_cnt;
    logic [FRAME_CNT_W-1:0] frame_cnt;
    logic [FRAME_CNT_W-1:0] frames_q;

    logic in_idle;
    logic in_run;
    logic xfer;
    logic last_digit;
    logic last_frame;

    lfsr_digit_step #(
        .LFSR_SIZE  (LFSR_SIZE),
        .RADIX_BITS (RADIX_BITS),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_step_x (
        .state_in  (lfsr_x),
        .state_out (lfsr_x_adv)
    );

    lfsr_digit_step #(
        .LFSR_SIZE  (LFSR_SIZE),
        .RADIX_BITS (RADIX_BITS),
        .LFSR_TAPS  (LFSR_TAPS)
    ) u_step_y (
        .state_in  (lfsr_y),
        .state_out (lfsr_y_adv)
    );

    assign in_idle = (state == ST_IDLE);
    assign in_run  = (state == ST_RUN);

    // stop wins over a same-cycle handshake: the offered digit stays unconsumed.
    assign xfer       = in_run && dig_ready && !stop;
    assign last_digit = (digit_cnt == LAST_DIG);
    assign last_frame = (frame_cnt == frames_q - FRAME_CNT_W'(1));

    // A zero seed (or all-ones seed on the inverted Y lane) would lock a lane.
    assign seed_x = (seed  == '0) ? LANE_ONE : seed;
    assign seed_y = (~seed == '0) ? LANE_ONE : ~seed;

    // FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= (num_frames != '0) ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (xfer && last_digit && last_frame) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // LFSR lanes: seeded in IDLE, advanced one digit per accepted transfer,
    // otherwise held so the next run picks up where the last one left off.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_x <= X_PRESET;
            lfsr_y <= Y_PRESET;
        end else if (in_idle && seed_load) begin
            lfsr_x <= seed_x;
            lfsr_y <= seed_y;
        end else if (xfer) begin
            lfsr_x <= lfsr_x_adv;
            lfsr_y <= lfsr_y_adv;
        end
    end

    // Digit / frame counters, cleared only when a run is started.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            digit_cnt <= '0;
            frame_cnt <= '0;
            frames_q  <= '0;
        end else if (in_idle && start) begin
            digit_cnt <= '0;
            frame_cnt <= '0;
            frames_q  <= num_frames;
        end else if (xfer) begin
            if (last_digit) begin
                digit_cnt <= '0;
                frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
            end else begin
                digit_cnt <= digit_cnt + CNT_W'(1);
            end
        end
    end

    // Outputs are decoded from registers only, so they are stable while stalled.
    assign busy      = in_run;
    assign done      = (state == ST_DONE);
    assign dig_valid = in_run;
    assign dig_x     = lfsr_x[RADIX_BITS-1:0];
    assign dig_y     = lfsr_y[RADIX_BITS-1:0];
    assign dig_first = in_run && (digit_cnt == '0);
    assign dig_last  = in_run && last_digit;
    assign frame_idx = frame_cnt;

endmodule
